// File: rtl/temporizador_ausencia.sv
// Absence timer: counts a no-presence interval in prescaled ticks while the
// lighting FSM holds enable, and returns a one-cycle timeout pulse to its c input.
module temporizador_ausencia #(
  parameter int PRESCALE = 1000,
  parameter int TIMEOUT  = 30,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          presenca,
  output logic          timeout,
  output logic [TW-1:0] remaining,
  output logic          ativo
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] RELOAD  = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, COUNTING, EXPIRED} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] prescaler, prescaler_nx;
  logic [TW-1:0] count, count_nx;
  logic          timeout_nx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      count     <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      prescaler <= prescaler_nx;
      count     <= count_nx;
      timeout   <= timeout_nx;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nx     = state;
    prescaler_nx = prescaler;
    count_nx     = count;
    timeout_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        prescaler_nx = '0;
        count_nx     = '0;
        if (enable) begin
          state_nx = COUNTING;
          count_nx = RELOAD;
        end
      end
      COUNTING: begin
        if (!enable) begin
          state_nx     = IDLE;
          count_nx     = '0;
          prescaler_nx = '0;
        end else if (presenca) begin
          count_nx     = RELOAD;
          prescaler_nx = '0;
        end else if (prescaler == PS_LAST) begin
          // count is always >= 1 here, so the decrement cannot wrap
          prescaler_nx = '0;
          count_nx     = count - 1'b1;
          if (count == TW'(1)) begin
            state_nx   = EXPIRED;
            timeout_nx = 1'b1;
          end
        end else begin
          prescaler_nx = prescaler + 1'b1;
        end
      end
      EXPIRED: begin
        prescaler_nx = '0;
        count_nx     = '0;
        if (!enable) state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        prescaler_nx = '0;
        count_nx     = '0;
      end
    endcase
  end

  assign remaining = count;
  assign ativo     = (state == COUNTING);

endmodule
